// File: rtl/video_pattern_gen.sv
// Raster timing generator with four selectable test patterns.
// Outputs are the source end of the vs/de/RGB888 stream.
module video_pattern_gen #(
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned H_FP      = 110,
  parameter int unsigned H_SYNC    = 40,
  parameter int unsigned H_BP      = 220,
  parameter int unsigned V_ACTIVE  = 720,
  parameter int unsigned V_FP      = 5,
  parameter int unsigned V_SYNC    = 5,
  parameter int unsigned V_BP      = 20,
  parameter bit          SYNC_POL  = 1'b1,
  parameter int unsigned CHK_SHIFT = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [1:0]  i_pattern_sel,
  input  logic [23:0] i_solid_rgb,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [23:0] o_data,
  output logic        o_frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // x must be at least 8 bits for the ramp and cover the checker bit.
  localparam int unsigned HW_CLOG = $clog2(H_TOTAL);
  localparam int unsigned HW_MIN  = (CHK_SHIFT + 1 > 8) ? CHK_SHIFT + 1 : 8;
  localparam int unsigned HW      = (HW_CLOG > HW_MIN) ? HW_CLOG : HW_MIN;
  localparam int unsigned VW_CLOG = $clog2(V_TOTAL);
  localparam int unsigned VW      = (VW_CLOG > CHK_SHIFT) ? VW_CLOG : CHK_SHIFT + 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam int unsigned  BAR_W    = H_ACTIVE / 8;
  localparam int unsigned  BCW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);

  logic [HW-1:0]  h_cnt_r;
  logic [VW-1:0]  v_cnt_r;
  logic [BCW-1:0] bar_cnt_r;
  logic [2:0]     bar_idx_r;
  logic [1:0]     pat_r;

  logic           first_s;
  logic           active_s;
  logic           hs_s;
  logic           vs_s;
  logic [1:0]     pat_s;
  logic [23:0]    pix_s;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      3'd7:    c = 24'h000000;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  assign first_s  = (h_cnt_r == '0) && (v_cnt_r == '0);
  // The selector is honoured on the (0,0) pixel itself, then held for the frame.
  assign pat_s    = first_s ? i_pattern_sel : pat_r;
  assign active_s = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
  assign hs_s     = (h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END);
  assign vs_s     = (v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END);

  // Pixel colour for the current counter position.
  always_comb begin
    pix_s = 24'h000000;
    case (pat_s)
      2'd0:    pix_s = bar_color(bar_idx_r);
      2'd1:    pix_s = {3{h_cnt_r[7:0]}};
      2'd2:    pix_s = (h_cnt_r[CHK_SHIFT] ^ v_cnt_r[CHK_SHIFT]) ? 24'h000000 : 24'hFFFFFF;
      2'd3:    pix_s = i_solid_rgb;
      default: pix_s = 24'h000000;
    endcase
  end

  // Raster counters, bar tracking and per-frame pattern latch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_cnt_r   <= '0;
      v_cnt_r   <= '0;
      bar_cnt_r <= '0;
      bar_idx_r <= 3'd0;
      pat_r     <= 2'd0;
    end else if (!i_en) begin
      h_cnt_r   <= '0;
      v_cnt_r   <= '0;
      bar_cnt_r <= '0;
      bar_idx_r <= 3'd0;
      pat_r     <= pat_r;
    end else begin
      pat_r <= pat_s;
      if (h_cnt_r == H_LAST) begin
        h_cnt_r   <= '0;
        bar_cnt_r <= '0;
        bar_idx_r <= 3'd0;
        v_cnt_r   <= (v_cnt_r == V_LAST) ? '0 : v_cnt_r + VW'(1);
      end else begin
        h_cnt_r <= h_cnt_r + HW'(1);
        v_cnt_r <= v_cnt_r;
        if (h_cnt_r < H_ACT_C) begin
          if (bar_cnt_r == BAR_LAST) begin
            bar_cnt_r <= '0;
            bar_idx_r <= bar_idx_r + 3'd1;
          end else begin
            bar_cnt_r <= bar_cnt_r + BCW'(1);
            bar_idx_r <= bar_idx_r;
          end
        end else begin
          bar_cnt_r <= bar_cnt_r;
          bar_idx_r <= bar_idx_r;
        end
      end
    end
  end

  // Registered video outputs, one cycle behind the counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hs          <= ~SYNC_POL;
      o_vs          <= ~SYNC_POL;
      o_de          <= 1'b0;
      o_data        <= 24'h000000;
      o_frame_start <= 1'b0;
    end else if (!i_en) begin
      o_hs          <= ~SYNC_POL;
      o_vs          <= ~SYNC_POL;
      o_de          <= 1'b0;
      o_data        <= 24'h000000;
      o_frame_start <= 1'b0;
    end else begin
      o_hs          <= hs_s ~^ SYNC_POL;
      o_vs          <= vs_s ~^ SYNC_POL;
      o_de          <= active_s;
      o_data        <= active_s ? pix_s : 24'h000000;
      o_frame_start <= first_s;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a 14x7 raster (8x4 active).
// Expected pixels come from a bar table and the pattern formulas.
module tb_video_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  sel;
  logic [23:0] solid;
  logic        o_hs;
  logic        o_vs;
  logic        o_de;
  logic [23:0] o_data;
  logic        o_frame_start;

  int checks = 0;
  int errors = 0;
  int pos = 0;
  int cyc = 0;
  int last_fs = -1;
  int de_n, hs_n, vs_n, fs_n;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .CHK_SHIFT(1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_en(en),
    .i_pattern_sel(sel),
    .i_solid_rgb(solid),
    .o_hs(o_hs),
    .o_vs(o_vs),
    .o_de(o_de),
    .o_data(o_data),
    .o_frame_start(o_frame_start)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (pos %0d)", tag, obs, exp, pos);
    end
  endtask

  task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (pos %0d)", tag, obs, exp, pos);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_de"}, o_de, 1'b0);
    chk1({tag, "_hs"}, o_hs, 1'b0);
    chk1({tag, "_vs"}, o_vs, 1'b0);
    chk24({tag, "_data"}, o_data, 24'h000000);
    chk1({tag, "_fs"}, o_frame_start, 1'b0);
  endtask

  function automatic logic [23:0] pix(input logic [1:0] pat, input int x, input int y);
    logic [7:0] xb;
    xb = x[7:0];
    case (pat)
      2'd0:    return bars[x];
      2'd1:    return {xb, xb, xb};
      2'd2:    return (x[1] ^ y[1]) ? 24'h000000 : 24'hFFFFFF;
      default: return solid;
    endcase
  endfunction

  // One clock: check the output carrying counter position pos.
  task automatic step(input logic [1:0] pat);
    int x;
    int y;
    logic e_de;
    @(posedge clk);
    #1;
    x = pos % 14;
    y = pos / 14;
    e_de = (x < 8) && (y < 4);
    chk1("de", o_de, e_de);
    chk1("hs", o_hs, (x >= 10) && (x < 12));
    chk1("vs", o_vs, y == 5);
    chk24("data", o_data, e_de ? pix(pat, x, y) : 24'h000000);
    chk1("frame_start", o_frame_start, pos == 0);
    de_n += int'(o_de);
    hs_n += int'(o_hs);
    vs_n += int'(o_vs);
    fs_n += int'(o_frame_start);
    if (o_frame_start) begin
      if (last_fs >= 0) chk_int("frame_period", cyc - last_fs, 98);
      last_fs = cyc;
    end
    cyc++;
    pos = (pos + 1) % 98;
  endtask

  task automatic run(input int n, input logic [1:0] pat, input int chg_at, input logic [1:0] chg_sel);
    de_n = 0;
    hs_n = 0;
    vs_n = 0;
    fs_n = 0;
    for (int i = 0; i < n; i++) begin
      if (pos == chg_at) sel = chg_sel;
      step(pat);
    end
    if (n == 98) begin
      chk_int("de_per_frame", de_n, 32);
      chk_int("hs_per_frame", hs_n, 14);
      chk_int("vs_per_frame", vs_n, 14);
      chk_int("fs_per_frame", fs_n, 1);
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    sel   = 2'd0;
    solid = 24'h000000;
    #3;
    chk_idle("reset");
    @(posedge clk);
    #1;
    chk_idle("reset_edge");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_idle("disabled");

    // Two bar frames: timing, bar colours and frame period.
    en  = 1'b1;
    pos = 0;
    run(98, 2'd0, -1, 2'd0);
    run(98, 2'd0, -1, 2'd0);

    // Switch to solid at line 2: this frame stays bars, next is solid.
    solid = 24'h123456;
    run(98, 2'd0, 28, 2'd3);
    run(98, 2'd3, 50, 2'd2);
    run(98, 2'd2, 50, 2'd1);
    run(98, 2'd1, -1, 2'd1);

    // Abort the frame after the output for (3,1).
    run(18, 2'd1, -1, 2'd1);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk_idle("en_drop");
    @(posedge clk);
    #1;
    chk_idle("en_low");

    // Restart always begins at (0,0) with a frame_start pulse.
    sel     = 2'd0;
    en      = 1'b1;
    pos     = 0;
    last_fs = -1;
    run(81, 2'd0, -1, 2'd0);

    // Output now shows (10,5): hs and vs both asserted; reset must clear them without a clock.
    #2;
    rst = 1'b1;
    #1;
    chk1("async_rst_hs", o_hs, 1'b0);
    chk1("async_rst_vs", o_vs, 1'b0);
    chk1("async_rst_de", o_de, 1'b0);
    chk24("async_rst_data", o_data, 24'h000000);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
